fpu_addsub_pipe: RTL and testbench

Three-stage pipelined single-precision floating-point add/subtract unit for the FPU path of the MIPS pipeline. It accepts ADD.S/SUB.S operand pairs issued from decode/execute (FPU start), runs them through Compare, Operate and Align stages, and delivers the result and destination FP register to writeback. It also exports per-stage destination addresses (Cfd, Ofd, Afd) to the hazard unit for stall and forward decisions.

---
 rtl/fpu_addsub_pipe.sv | 174 +++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// Three-stage (Compare / Operate / Align) float32 add/subtract pipeline with truncating rounding.
// Define FPU_DENORM_EN to handle subnormal operands and results instead of flushing them to zero.
module fpu_addsub_pipe #(
  parameter int DST_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [DST_W-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_val,
  output logic [DST_W-1:0] out_dst,
  output logic             c_valid,
  output logic             o_valid,
  output logic             a_valid,
  output logic [DST_W-1:0] c_dst,
  output logic [DST_W-1:0] o_dst,
  output logic [DST_W-1:0] a_dst
);

  logic             stall;
  logic             c_v, o_v, a_v;
  logic [DST_W-1:0] c_d, o_d, a_d;
  logic             c_gt_s, c_lt_s;
  logic [7:0]       c_exp, c_e_dif;
  logic [23:0]      c_gt_m, c_lt_m;
  logic             o_s;
  logic [7:0]       o_e;
  logic [24:0]      o_m;
  logic [31:0]      a_val;

  function automatic logic [7:0] eff_exp(input logic [7:0] e);
`ifdef FPU_DENORM_EN
    return (e == 8'd0) ? 8'd1 : e;
`else
    return e;
`endif
  endfunction

  // Mantissa with hidden bit; exp=0 operands are either subnormal or read as zero.
  function automatic logic [23:0] ext_mnt(input logic [30:0] f);
`ifdef FPU_DENORM_EN
    return {f[30:23] != 8'd0, f[22:0]};
`else
    return (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
`endif
  endfunction

  function automatic logic [4:0] lzc(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  logic [31:0] b_eff, gt, lt;
  logic        a_ge;
  logic [7:0]  gt_e, lt_e;

  always_comb begin
    b_eff = {in_b[31] ^ in_op, in_b[30:0]};
    a_ge  = in_a[30:0] >= b_eff[30:0];
    gt    = a_ge ? in_a : b_eff;
    lt    = a_ge ? b_eff : in_a;
    gt_e  = eff_exp(gt[30:23]);
    lt_e  = eff_exp(lt[30:23]);
  end

  logic [23:0] lt_sh;
  logic [24:0] sum;

  always_comb begin
    lt_sh = (c_e_dif >= 8'd25) ? 24'd0 : (c_lt_m >> c_e_dif);
    sum   = (c_gt_s == c_lt_s) ? ({1'b0, c_gt_m} + {1'b0, lt_sh})
                               : ({1'b0, c_gt_m} - {1'b0, lt_sh});
  end

  logic [4:0]  lz;
  logic [23:0] shl;
  logic [8:0]  exp_inc;
  logic [31:0] norm_val;

  // Normalise: carry shifts right, cancellation shifts left; underflow and overflow saturate.
  always_comb begin
    lz       = lzc(o_m[23:0]);
    shl      = o_m[23:0] << lz;
    exp_inc  = {1'b0, o_e} + 9'd1;
    norm_val = 32'd0;
    if (o_m == 25'd0) begin
      norm_val = 32'd0;
    end else if (o_m[24]) begin
      if (exp_inc >= 9'd255) norm_val = {o_s, 8'hFF, 23'd0};
      else                   norm_val = {o_s, exp_inc[7:0], o_m[23:1]};
    end else if (o_e <= {3'b000, lz}) begin
`ifdef FPU_DENORM_EN
      norm_val = {o_s, 8'h00, 23'(o_m[23:0] << (o_e - 8'd1))};
`else
      norm_val = {o_s, 31'd0};
`endif
    end else begin
      norm_val = {o_s, o_e - {3'b000, lz}, shl[22:0]};
    end
  end

  assign stall     = a_v & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = a_v;
  assign out_val   = a_val;
  assign out_dst   = a_d;
  assign c_valid   = c_v;
  assign o_valid   = o_v;
  assign a_valid   = a_v;
  assign c_dst     = c_v ? c_d : '0;
  assign o_dst     = o_v ? o_d : '0;
  assign a_dst     = a_v ? a_d : '0;

  // All stages shift together or hold together; payloads only load behind a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_v     <= 1'b0;
      o_v     <= 1'b0;
      a_v     <= 1'b0;
      c_d     <= '0;
      o_d     <= '0;
      a_d     <= '0;
      c_gt_s  <= 1'b0;
      c_lt_s  <= 1'b0;
      c_exp   <= 8'd0;
      c_e_dif <= 8'd0;
      c_gt_m  <= 24'd0;
      c_lt_m  <= 24'd0;
      o_s     <= 1'b0;
      o_e     <= 8'd0;
      o_m     <= 25'd0;
      a_val   <= 32'd0;
    end else if (flush) begin
      c_v <= 1'b0;
      o_v <= 1'b0;
      a_v <= 1'b0;
    end else if (!stall) begin
      c_v <= in_valid;
      o_v <= c_v;
      a_v <= o_v;
      if (in_valid) begin
        c_d     <= in_dst;
        c_gt_s  <= gt[31];
        c_lt_s  <= lt[31];
        c_exp   <= gt_e;
        c_e_dif <= gt_e - lt_e;
        c_gt_m  <= ext_mnt(gt[30:0]);
        c_lt_m  <= ext_mnt(lt[30:0]);
      end
      if (c_v) begin
        o_d <= c_d;
        o_s <= c_gt_s;
        o_e <= c_exp;
        o_m <= sum;
      end
      if (o_v) begin
        a_d   <= o_d;
        a_val <= norm_val;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Self-checking bench for fpu_addsub_pipe: directed vectors, scripted stall, random stream, flush and reset.
module tb_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_dst = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_val;
  logic [4:0]  out_dst;
  logic        c_valid, o_valid, a_valid;
  logic [4:0]  c_dst, o_dst, a_dst;

  int checks = 0;
  int passed = 0;

  fpu_addsub_pipe #(.DST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_dst(out_dst),
    .c_valid(c_valid), .o_valid(o_valid), .a_valid(a_valid),
    .c_dst(c_dst), .o_dst(o_dst), .a_dst(a_dst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Value of a float as integer mantissa scaled by 2^(exp - bias - 23).
  function automatic void unpack_f(input logic [31:0] f, output int e, output longint m);
    e = int'(f[30:23]);
`ifdef FPU_DENORM_EN
    if (e == 0) begin
      e = 1;
      m = longint'(f[22:0]);
    end else begin
      m = (longint'(1) << 23) + longint'(f[22:0]);
    end
`else
    m = (e == 0) ? 0 : (longint'(1) << 23) + longint'(f[22:0]);
`endif
  endfunction

  function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] bb, g, l;
    int          eg, el, e;
    longint      mg, ml, m;
    logic        s;
    bb = {b[31] ^ op, b[30:0]};
    if (a[30:0] >= bb[30:0]) begin g = a; l = bb; end
    else begin g = bb; l = a; end
    unpack_f(g, eg, mg);
    unpack_f(l, el, ml);
    if (eg - el >= 25) ml = 0;
    else ml = ml / (longint'(1) << (eg - el));
    s = g[31];
    m = (g[31] == l[31]) ? mg + ml : mg - ml;
    e = eg;
    if (m == 0) return 32'h0;
    while (m >= 16777216) begin m = m / 2; e++; end
    while (m < 8388608) begin m = m * 2; e--; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) begin
`ifdef FPU_DENORM_EN
      m = m / (longint'(1) << (1 - e));
      return {s, 8'h00, m[22:0]};
`else
      return {s, 31'h0};
`endif
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_float(input int near_exp);
    int e;
    if (near_exp >= 0 && $urandom_range(0, 1) == 1) e = near_exp + int'($urandom_range(0, 4)) - 2;
    else if ($urandom_range(0, 7) == 0) e = 0;
    else e = int'($urandom_range(1, 254));
    if (e < 0) e = 0;
    if (e > 254) e = 254;
    return {1'($urandom_range(0, 1)), e[7:0], 23'($urandom)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({c_valid, o_valid, a_valid, out_valid} !== 4'b0000)
      $display("[TB] FAIL reset_valids: got %b expected 0000", {c_valid, o_valid, a_valid, out_valid});
    else passed++;
    checks++;
    if ({c_dst, o_dst, a_dst} !== 15'd0) $display("[TB] FAIL reset_dsts: got %h expected 0", {c_dst, o_dst, a_dst});
    else passed++;
    checks++;
    if (out_val !== 32'd0) $display("[TB] FAIL reset_out_val: got %h expected 0", out_val);
    else passed++;
    checks++;
    if (out_dst !== 5'd0) $display("[TB] FAIL reset_out_dst: got %0d expected 0", out_dst);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h4B800000, 32'h00400000};
    logic [31:0] vb [6] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h00400000};
    logic        vop [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef FPU_DENORM_EN
    logic [31:0] vr [6] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h4B800000, 32'h00800000};
`else
    logic [31:0] vr [6] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h4B800000, 32'h00000000};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_op = vop[i]; in_dst = 5'(i + 3);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({c_valid, c_dst} !== {1'b1, 5'(i + 3)})
        $display("[TB] FAIL dir%0d_c_stage: got %b/%0d expected 1/%0d", i, c_valid, c_dst, i + 3);
      else passed++;
      @(negedge clk);
      checks++;
      if ({out_valid, o_valid, o_dst} !== {1'b0, 1'b1, 5'(i + 3)})
        $display("[TB] FAIL dir%0d_latency: got out_valid=%b o=%b/%0d expected 0 1/%0d", i, out_valid, o_valid, o_dst, i + 3);
      else passed++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) $display("[TB] FAIL dir%0d_out_valid: got %b expected 1", i, out_valid);
      else passed++;
      checks++;
      if (out_val !== vr[i]) $display("[TB] FAIL dir%0d_out_val: got %h expected %h", i, out_val, vr[i]);
      else passed++;
      checks++;
      if (out_dst !== 5'(i + 3)) $display("[TB] FAIL dir%0d_out_dst: got %0d expected %0d", i, out_dst, i + 3);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [4] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40800000};
    logic [31:0] bv [4] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h3F800000};
    logic        bop [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          drv [10] = '{0, 1, 2, 3, 3, 3, -1, -1, -1, -1};
    logic        rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        eov [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ev [10] = '{32'h0, 32'h0, 32'h0, 32'h40400000, 32'h40400000, 32'h40400000,
                             32'h40400000, 32'h3F800000, 32'h40A00000, 32'h0};
    logic [4:0]  ea [10] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
    logic [4:0]  eo [10] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0};
    logic [4:0]  ec [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0};
    int          delivered = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = rdy[k];
      if (drv[k] >= 0) begin
        in_valid = 1'b1; in_a = ba[drv[k]]; in_b = bv[drv[k]]; in_op = bop[drv[k]]; in_dst = 5'(drv[k] + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (out_valid !== eov[k]) $display("[TB] FAIL b2b%0d_out_valid: got %b expected %b", k, out_valid, eov[k]);
      else passed++;
      checks++;
      if (in_ready !== rdy[k]) $display("[TB] FAIL b2b%0d_in_ready: got %b expected %b", k, in_ready, rdy[k]);
      else passed++;
      checks++;
      if ({c_dst, o_dst, a_dst} !== {ec[k], eo[k], ea[k]})
        $display("[TB] FAIL b2b%0d_stage_dst: got c%0d o%0d a%0d expected c%0d o%0d a%0d",
                 k, c_dst, o_dst, a_dst, ec[k], eo[k], ea[k]);
      else passed++;
      if (eov[k]) begin
        checks++;
        if (out_val !== ev[k]) $display("[TB] FAIL b2b%0d_out_val: got %h expected %h", k, out_val, ev[k]);
        else passed++;
      end
      if (out_valid && out_ready) delivered++;
    end
    in_valid = 1'b0;
    checks++;
    if (delivered != 4) $display("[TB] FAIL b2b_delivered: got %0d expected 4", delivered);
    else passed++;
  endtask

  task automatic test_random();
    logic [36:0] sb [$];
    logic [36:0] exp_item;
    int          issued = 0;
    int          got = 0;
    int          cyc = 0;
    int          n_ops = 300;
    while ((issued < n_ops || sb.size() > 0 || out_valid) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (issued < n_ops) && ($urandom_range(0, 4) != 0);
      in_a      = rnd_float(-1);
      in_b      = rnd_float(int'(in_a[30:23]));
      in_op     = 1'($urandom_range(0, 1));
      in_dst    = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("[TB] FAIL rnd_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
      else passed++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL rnd_spurious: got dst %0d val %h expected no output", out_dst, out_val);
        end else begin
          exp_item = sb.pop_front();
          if ({out_dst, out_val} !== exp_item)
            $display("[TB] FAIL rnd_result: got dst %0d val %h expected dst %0d val %h",
                     out_dst, out_val, exp_item[36:32], exp_item[31:0]);
          else passed++;
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_dst, ref_addsub(in_a, in_b, in_op)});
        issued++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 5000) $display("[TB] FAIL rnd_timeout: got %0d cycles expected under 5000", cyc);
    else passed++;
    checks++;
    if (got != n_ops) $display("[TB] FAIL rnd_count: got %0d results expected %0d", got, n_ops);
    else passed++;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 1'b0; in_dst = 5'(10 + i);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({c_valid, o_valid, a_valid} !== 3'b111)
      $display("[TB] FAIL flush_pre_occupancy: got %b expected 111", {c_valid, o_valid, a_valid});
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({c_valid, o_valid, a_valid, out_valid} !== 4'b0000)
      $display("[TB] FAIL flush_valids: got %b expected 0000", {c_valid, o_valid, a_valid, out_valid});
    else passed++;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL flush_no_output: got %0d outputs expected 0", seen);
    else passed++;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_dst = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_dst, out_val} !== {1'b1, 5'd9, 32'h40400000})
      $display("[TB] FAIL flush_recover: got %b/%0d/%h expected 1/9/40400000", out_valid, out_dst, out_val);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000; in_op = 1'b0; in_dst = 5'd7;
    @(negedge clk);
    in_dst = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({c_valid, o_valid} !== 2'b11) $display("[TB] FAIL rstmid_pre: got %b expected 11", {c_valid, o_valid});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({c_valid, o_valid, a_valid, out_valid} !== 4'b0000)
      $display("[TB] FAIL rstmid_valids: got %b expected 0000", {c_valid, o_valid, a_valid, out_valid});
    else passed++;
    checks++;
    if ({out_val, out_dst, c_dst, o_dst, a_dst} !== 52'd0)
      $display("[TB] FAIL rstmid_payload: got val %h dst %0d expected 0 0", out_val, out_dst);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL rstmid_no_output: got %0d outputs expected 0", seen);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
